// File: rtl/l2_vc_requester_pkg.sv
// Shared types for the L2 <-> victim-cache requester: line/address types and FSM state encoding.
package lc3b_types;

  localparam int L2VC_ADDR_W = 12;
  localparam int L2VC_LINE_W = 128;

  typedef logic [L2VC_LINE_W-1:0] lc3b_line;
  typedef logic [L2VC_ADDR_W-1:0] lc3b_line_addr;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } l2vc_state_t;

endpackage

// File: rtl/l2_vc_requester_victim_buffer.sv
// Single-entry victim line buffer with load/clear controls and an address-match output.
module l2vc_victim_buffer #(
  parameter int ADDR_W = 12,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LINE_W-1:0] load_data,
  input  logic              load_dirty,
  input  logic              clear,
  input  logic [ADDR_W-1:0] query_addr,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [LINE_W-1:0] data,
  output logic              dirty,
  output logic              hit
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
      dirty <= 1'b0;
    end else begin
      if (load) begin
        valid <= 1'b1;
        addr  <= load_addr;
        data  <= load_data;
        dirty <= load_dirty;
      end else if (clear) begin
        valid <= 1'b0;
      end
    end
  end

  // A line being loaded this cycle is not yet valid, so it can never match.
  assign hit = valid && (addr == query_addr);

endmodule

// File: rtl/l2_vc_requester.sv
// L2-side initiator to the victim cache: buffers one victim line, issues single-outstanding
// read/write commands, and returns fills (forwarded from the buffer on an address hit).
//
// state | meaning
// IDLE  | accepting misses; drains a buffered victim when no miss is taken
// READ  | vc_read held, waiting for vc_resp with fill data
// WRITE | vc_write held with the buffered line, waiting for vc_resp
// RESP  | fill_valid pulse cycle, then back to IDLE
module l2_vc_requester
  import lc3b_types::*;
#(
  parameter int ADDR_W = L2VC_ADDR_W,
  parameter int LINE_W = L2VC_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              evict_valid,
  input  logic [ADDR_W-1:0] evict_addr,
  input  logic [LINE_W-1:0] evict_data,
  input  logic              evict_dirty,
  output logic              evict_ready,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              miss_ready,
  output logic              fill_valid,
  output logic [LINE_W-1:0] fill_data,
  output logic              fill_dirty,
  output logic [ADDR_W-1:0] vc_address,
  output logic [LINE_W-1:0] vc_wdata,
  output logic              vc_dirty_bit,
  output logic              vc_read,
  output logic              vc_write,
  input  logic              vc_resp,
  input  logic [LINE_W-1:0] vc_rdata,
  input  logic              vc_rdirty
);

  l2vc_state_t       state;
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_addr;
  logic [LINE_W-1:0] buf_data;
  logic              buf_dirty;
  logic              buf_hit;
  logic              buf_load;
  logic              buf_clear;
  logic              miss_fire;

  assign evict_ready = !buf_valid;
  assign miss_ready  = (state == IDLE);
  assign miss_fire   = miss_valid && miss_ready;
  assign buf_load    = evict_valid && evict_ready;
  assign buf_clear   = (miss_fire && buf_hit) || (state == WRITE && vc_resp);

  l2vc_victim_buffer #(
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (buf_load),
    .load_addr (evict_addr),
    .load_data (evict_data),
    .load_dirty(evict_dirty),
    .clear     (buf_clear),
    .query_addr(miss_addr),
    .valid     (buf_valid),
    .addr      (buf_addr),
    .data      (buf_data),
    .dirty     (buf_dirty),
    .hit       (buf_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      fill_valid   <= 1'b0;
      fill_data    <= '0;
      fill_dirty   <= 1'b0;
      vc_address   <= '0;
      vc_wdata     <= '0;
      vc_dirty_bit <= 1'b0;
      vc_read      <= 1'b0;
      vc_write     <= 1'b0;
    end else begin
      fill_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (miss_fire) begin
            if (buf_hit) begin
              fill_valid <= 1'b1;
              fill_data  <= buf_data;
              fill_dirty <= buf_dirty;
              state      <= RESP;
            end else begin
              vc_address <= miss_addr;
              vc_read    <= 1'b1;
              state      <= READ;
            end
          end else if (buf_valid) begin
            vc_address   <= buf_addr;
            vc_wdata     <= buf_data;
            vc_dirty_bit <= buf_dirty;
            vc_write     <= 1'b1;
            state        <= WRITE;
          end
        end
        READ: begin
          if (vc_resp) begin
            vc_read    <= 1'b0;
            fill_valid <= 1'b1;
            fill_data  <= vc_rdata;
            fill_dirty <= vc_rdirty;
            state      <= RESP;
          end
        end
        WRITE: begin
          if (vc_resp) begin
            vc_write <= 1'b0;
            state    <= IDLE;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
